// File: rtl/module_rca_secuenciador.sv
// ----------------------------------------------------------------------------
// module_rca_secuenciador
//
// Sequential front-end for module_ripple_carry_adder. Collects operand A and
// then operand B from one data bus (valid/ready), holds them on registers that
// feed the combinational adder, waits CICLOS_ASENTAMIENTO cycles for the ripple
// chain to settle, registers the sum plus a carry-out derived from the operand
// and sum MSBs, and offers the result through a valid/ready output handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   dato_i       operand word (first accepted = A, second = B)
//   valido_i     dato_i valid
//   listo_o      block can accept an operand word
//   A_o, B_o     registered operands to the adder
//   S_i          sum returned by the adder
//   resultado_o  registered sum (modulo 2^ANCHO)
//   acarreo_o    registered carry-out
//   valido_o     resultado_o/acarreo_o valid
//   listo_i      downstream accepts the result
//   num_sumas_o  number of results delivered, wraps 255 -> 0
// ----------------------------------------------------------------------------
module module_rca_secuenciador #(
    parameter int ANCHO               = 8,
    parameter int CICLOS_ASENTAMIENTO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] dato_i,
    input  logic             valido_i,
    output logic             listo_o,
    output logic [ANCHO-1:0] A_o,
    output logic [ANCHO-1:0] B_o,
    input  logic [ANCHO-1:0] S_i,
    output logic [ANCHO-1:0] resultado_o,
    output logic             acarreo_o,
    output logic             valido_o,
    input  logic             listo_i,
    output logic [7:0]       num_sumas_o
);

    localparam int CW = $clog2(CICLOS_ASENTAMIENTO + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_ASENTAMIENTO - 1);

    typedef enum logic [1:0] {
        ESPERA_A = 2'd0,
        ESPERA_B = 2'd1,
        ASENTAR  = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    estado_t          r_estado;
    estado_t          w_siguiente;
    logic             w_listo_estado;
    logic [CW-1:0]    r_cnt;
    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_b;
    logic [ANCHO-1:0] r_resultado;
    logic             r_acarreo;
    logic             r_valido;
    logic [7:0]       r_num;
    logic             w_fin_asentar;
    logic             w_acarreo;

    assign w_fin_asentar = (r_cnt == ULTIMO);

    // Carry recovered from MSBs only: both set always carries; exactly one set
    // carries when the sum MSB came out 0 (a carry entered the MSB position).
    assign w_acarreo = (r_a[ANCHO-1] & r_b[ANCHO-1])
                     | ((r_a[ANCHO-1] | r_b[ANCHO-1]) & ~S_i[ANCHO-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= ESPERA_A;
        end else begin
            r_estado <= w_siguiente;
        end
    end

    always_comb begin
        w_siguiente    = r_estado;
        w_listo_estado = 1'b0;
        case (r_estado)
            ESPERA_A: begin
                w_listo_estado = 1'b1;
                if (valido_i) w_siguiente = ESPERA_B;
            end
            ESPERA_B: begin
                w_listo_estado = 1'b1;
                if (valido_i) w_siguiente = ASENTAR;
            end
            ASENTAR: begin
                if (w_fin_asentar) w_siguiente = ENTREGA;
            end
            ENTREGA: begin
                if (listo_i) w_siguiente = ESPERA_A;
            end
            default: w_siguiente = ESPERA_A;
        endcase
    end

    // Gated with rst so ready drops the instant reset is asserted.
    assign listo_o = w_listo_estado & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_resultado <= '0;
            r_acarreo   <= 1'b0;
            r_valido    <= 1'b0;
            r_num       <= '0;
        end else begin
            case (r_estado)
                ESPERA_A: begin
                    if (valido_i) r_a <= dato_i;
                end
                ESPERA_B: begin
                    if (valido_i) begin
                        r_b   <= dato_i;
                        r_cnt <= '0;
                    end
                end
                ASENTAR: begin
                    if (w_fin_asentar) begin
                        r_resultado <= S_i;
                        r_acarreo   <= w_acarreo;
                        r_valido    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ENTREGA: begin
                    if (listo_i) begin
                        r_valido <= 1'b0;
                        r_num    <= r_num + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign A_o         = r_a;
    assign B_o         = r_b;
    assign resultado_o = r_resultado;
    assign acarreo_o   = r_acarreo;
    assign valido_o    = r_valido;
    assign num_sumas_o = r_num;

endmodule

// File: tb/tb_module_rca_secuenciador.sv
// ----------------------------------------------------------------------------
// tb_module_rca_secuenciador
//
// Directed bench for module_rca_secuenciador. The adder is modelled by a
// continuous A_o + B_o so the block sees a real sum; all expected values are
// hand-computed constants. A second instance with CICLOS_ASENTAMIENTO=3
// exercises the longer settling latency.
// ----------------------------------------------------------------------------
module tb_module_rca_secuenciador;

    logic       clk;
    logic       rst;
    logic [7:0] dato_i;
    logic       valido_i;
    logic       listo_o;
    logic [7:0] a_o;
    logic [7:0] b_o;
    logic [7:0] s_i;
    logic [7:0] resultado_o;
    logic       acarreo_o;
    logic       valido_o;
    logic       listo_i;
    logic [7:0] num_sumas_o;

    logic [7:0] dato3;
    logic       valido3;
    logic       listo3_o;
    logic [7:0] a3;
    logic [7:0] b3;
    logic [7:0] s3;
    logic [7:0] res3;
    logic       carry3;
    logic       valido3_o;
    logic       listo3_i;
    logic [7:0] num3;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [7:0]  exp_num;

    assign s_i = a_o + b_o;
    assign s3  = a3 + b3;

    module_rca_secuenciador #(
        .ANCHO(8),
        .CICLOS_ASENTAMIENTO(2)
    ) dut (
        .clk(clk), .rst(rst), .dato_i(dato_i), .valido_i(valido_i),
        .listo_o(listo_o), .A_o(a_o), .B_o(b_o), .S_i(s_i),
        .resultado_o(resultado_o), .acarreo_o(acarreo_o), .valido_o(valido_o),
        .listo_i(listo_i), .num_sumas_o(num_sumas_o)
    );

    module_rca_secuenciador #(
        .ANCHO(8),
        .CICLOS_ASENTAMIENTO(3)
    ) dut3 (
        .clk(clk), .rst(rst), .dato_i(dato3), .valido_i(valido3),
        .listo_o(listo3_o), .A_o(a3), .B_o(b3), .S_i(s3),
        .resultado_o(res3), .acarreo_o(carry3), .valido_o(valido3_o),
        .listo_i(listo3_i), .num_sumas_o(num3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; returns once it has been accepted (bounded).
    task automatic send_word(input logic [7:0] w, input string tag);
        bit done;
        done     = 1'b0;
        valido_i = 1'b1;
        dato_i   = w;
        for (int i = 0; i < 50; i++) begin
            if (listo_o) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        valido_i = 1'b0;
        check({tag, "_accept_timeout"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (valido_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_valid_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic consume(input string tag);
        listo_i = 1'b1;
        tick();
        listo_i = 1'b0;
        exp_num = exp_num + 8'd1;
        check({tag, "_valido_low"}, {31'd0, valido_o}, 32'd0);
        check({tag, "_listo_high"}, {31'd0, listo_o}, 32'd1);
        check({tag, "_num"}, {24'd0, num_sumas_o}, {24'd0, exp_num});
    endtask

    task automatic do_sum(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input string tag);
        send_word(a, {tag, "_A"});
        send_word(b, {tag, "_B"});
        wait_valid(tag);
        check({tag, "_sum"}, {24'd0, resultado_o}, {24'd0, es});
        check({tag, "_carry"}, {31'd0, acarreo_o}, {31'd0, ec});
        consume(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_num  = 8'd0;
        rst      = 1'b1;
        dato_i   = 8'd0;
        valido_i = 1'b0;
        listo_i  = 1'b0;
        dato3    = 8'd0;
        valido3  = 1'b0;
        listo3_i = 1'b0;

        #2;
        check("rst_listo", {31'd0, listo_o}, 32'd0);
        tick();
        tick();
        check("rst_A", {24'd0, a_o}, 32'd0);
        check("rst_B", {24'd0, b_o}, 32'd0);
        check("rst_res", {24'd0, resultado_o}, 32'd0);
        check("rst_carry", {31'd0, acarreo_o}, 32'd0);
        check("rst_valido", {31'd0, valido_o}, 32'd0);
        check("rst_num", {24'd0, num_sumas_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_listo", {31'd0, listo_o}, 32'd1);
        tick();

        // 1: wrap-around FF+01, valid two edges after B acceptance
        send_word(8'hFF, "t1_A");
        send_word(8'h01, "t1_B");
        check("t1_lat_e1", {31'd0, valido_o}, 32'd0);
        tick();
        check("t1_lat_e1b", {31'd0, valido_o}, 32'd0);
        tick();
        check("t1_lat_e2", {31'd0, valido_o}, 32'd1);
        check("t1_sum", {24'd0, resultado_o}, 32'h00);
        check("t1_carry", {31'd0, acarreo_o}, 32'd1);
        consume("t1");

        // 2: no carry, operands stable during settling
        send_word(8'h12, "t2_A");
        send_word(8'h34, "t2_B");
        for (int i = 0; i < 2; i++) begin
            check("t2_A_hold", {24'd0, a_o}, 32'h12);
            check("t2_B_hold", {24'd0, b_o}, 32'h34);
            check("t2_listo_low", {31'd0, listo_o}, 32'd0);
            tick();
        end
        check("t2_valido", {31'd0, valido_o}, 32'd1);
        check("t2_sum", {24'd0, resultado_o}, 32'h46);
        check("t2_carry", {31'd0, acarreo_o}, 32'd0);
        consume("t2");

        // 3: backpressure on 80+80
        send_word(8'h80, "t3_A");
        send_word(8'h80, "t3_B");
        wait_valid("t3");
        for (int i = 0; i < 5; i++) begin
            check("t3_sum_hold", {24'd0, resultado_o}, 32'h00);
            check("t3_carry_hold", {31'd0, acarreo_o}, 32'd1);
            check("t3_valido_hold", {31'd0, valido_o}, 32'd1);
            check("t3_listo_low", {31'd0, listo_o}, 32'd0);
            tick();
        end
        consume("t3");

        // 4: gap between A and B, then valid asserted while busy
        send_word(8'h0F, "t4_A");
        for (int i = 0; i < 4; i++) begin
            check("t4_A_gap", {24'd0, a_o}, 32'h0F);
            check("t4_listo_gap", {31'd0, listo_o}, 32'd1);
            tick();
        end
        send_word(8'hF0, "t4_B");
        valido_i = 1'b1;
        dato_i   = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check("t4_busy_A", {24'd0, a_o}, 32'h0F);
            check("t4_busy_B", {24'd0, b_o}, 32'hF0);
            tick();
        end
        valido_i = 1'b0;
        check("t4_valido", {31'd0, valido_o}, 32'd1);
        check("t4_sum", {24'd0, resultado_o}, 32'hFF);
        check("t4_carry", {31'd0, acarreo_o}, 32'd0);
        consume("t4");

        // 5: asynchronous reset during settling
        send_word(8'h77, "t5_A");
        send_word(8'h99, "t5_B");
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_A", {24'd0, a_o}, 32'd0);
        check("t5_rst_B", {24'd0, b_o}, 32'd0);
        check("t5_rst_res", {24'd0, resultado_o}, 32'd0);
        check("t5_rst_carry", {31'd0, acarreo_o}, 32'd0);
        check("t5_rst_valido", {31'd0, valido_o}, 32'd0);
        check("t5_rst_num", {24'd0, num_sumas_o}, 32'd0);
        check("t5_rst_listo", {31'd0, listo_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_num = 8'd0;
        tick();
        do_sum(8'h01, 8'h01, 8'h02, 1'b0, "t5_fresh");

        // 6a: CICLOS_ASENTAMIENTO=3 instance latency
        valido3 = 1'b1;
        dato3   = 8'h03;
        check("t6_listo3", {31'd0, listo3_o}, 32'd1);
        tick();
        dato3 = 8'h04;
        check("t6_listo3_b", {31'd0, listo3_o}, 32'd1);
        tick();
        valido3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_lat_low", {31'd0, valido3_o}, 32'd0);
            tick();
        end
        check("t6_lat_high", {31'd0, valido3_o}, 32'd1);
        check("t6_sum3", {24'd0, res3}, 32'h07);
        check("t6_carry3", {31'd0, carry3}, 32'd0);
        listo3_i = 1'b1;
        tick();
        listo3_i = 1'b0;
        check("t6_num3", {24'd0, num3}, 32'd1);

        // 6b: 256 sums from a clean reset wrap the counter to 0
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        exp_num = 8'd0;
        tick();
        for (int i = 0; i < 256; i++) begin
            send_word(8'h10, "t6w_A");
            send_word(8'h20, "t6w_B");
            wait_valid("t6w");
            listo_i = 1'b1;
            tick();
            listo_i = 1'b0;
            if (i == 0) check("t6w_first_sum", {24'd0, resultado_o}, 32'h30);
            if (i == 254) check("t6w_num_ff", {24'd0, num_sumas_o}, 32'hFF);
        end
        check("t6w_num_wrap", {24'd0, num_sumas_o}, 32'h00);
        check("t6w_listo_end", {31'd0, listo_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
